// File: rtl/alu_unit.sv
`default_nettype none
// ============================================================================
//  Module      : alu_unit
//  Description : 32-bit integer ALU for the execute stage. Computes one of
//                sixteen RV32I-style operations selected by a 5-bit opcode
//                and registers the result (one-cycle latency).
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_unit #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST_X,
    input  logic [WIDTH-1:0] lhs,
    input  logic [WIDTH-1:0] rhs,
    input  logic [4:0]       op,
    output logic [WIDTH-1:0] res
);

    // Opcode map; everything from 17 upward is reserved and yields zero.
    localparam logic [4:0] c_OP_NOP  = 5'd0;
    localparam logic [4:0] c_OP_ADD  = 5'd1;
    localparam logic [4:0] c_OP_SUB  = 5'd2;
    localparam logic [4:0] c_OP_SLL  = 5'd3;
    localparam logic [4:0] c_OP_SLT  = 5'd4;
    localparam logic [4:0] c_OP_SLTU = 5'd5;
    localparam logic [4:0] c_OP_XOR  = 5'd6;
    localparam logic [4:0] c_OP_SRL  = 5'd7;
    localparam logic [4:0] c_OP_SRA  = 5'd8;
    localparam logic [4:0] c_OP_OR   = 5'd9;
    localparam logic [4:0] c_OP_AND  = 5'd10;
    localparam logic [4:0] c_OP_EQ   = 5'd11;
    localparam logic [4:0] c_OP_NEQ  = 5'd12;
    localparam logic [4:0] c_OP_LT   = 5'd13;
    localparam logic [4:0] c_OP_GE   = 5'd14;
    localparam logic [4:0] c_OP_LTU  = 5'd15;
    localparam logic [4:0] c_OP_GEU  = 5'd16;

    localparam logic [WIDTH-2:0] c_BOOL_PAD = '0;

    // Shift amount is always the low five bits; the upper rhs bits are ignored.
    logic [4:0]       w_shamt;
    logic             w_lt_s;
    logic             w_lt_u;
    logic             w_eq;
    logic [WIDTH-1:0] w_result;
    logic [WIDTH-1:0] r_res;

    assign w_shamt = rhs[4:0];
    assign w_lt_s  = $signed(lhs) < $signed(rhs);
    assign w_lt_u  = lhs < rhs;
    assign w_eq    = lhs == rhs;

    // Operation select; defaulting to zero keeps reserved opcodes defined.
    always_comb begin
        w_result = '0;
        case (op)
            c_OP_NOP:  w_result = '0;
            c_OP_ADD:  w_result = lhs + rhs;
            c_OP_SUB:  w_result = lhs - rhs;
            c_OP_SLL:  w_result = lhs << w_shamt;
            c_OP_SLT:  w_result = {c_BOOL_PAD, w_lt_s};
            c_OP_SLTU: w_result = {c_BOOL_PAD, w_lt_u};
            c_OP_XOR:  w_result = lhs ^ rhs;
            c_OP_SRL:  w_result = lhs >> w_shamt;
            c_OP_SRA:  w_result = $signed(lhs) >>> w_shamt;
            c_OP_OR:   w_result = lhs | rhs;
            c_OP_AND:  w_result = lhs & rhs;
            c_OP_EQ:   w_result = {c_BOOL_PAD, w_eq};
            c_OP_NEQ:  w_result = {c_BOOL_PAD, ~w_eq};
            c_OP_LT:   w_result = {c_BOOL_PAD, w_lt_s};
            c_OP_GE:   w_result = {c_BOOL_PAD, ~w_lt_s};
            c_OP_LTU:  w_result = {c_BOOL_PAD, w_lt_u};
            c_OP_GEU:  w_result = {c_BOOL_PAD, ~w_lt_u};
            default:   w_result = '0;
        endcase
    end

    // Result register; reset clears it immediately and holds it at zero.
    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            r_res <= '0;
        end else begin
            r_res <= w_result;
        end
    end

    assign res = r_res;

endmodule
`default_nettype wire

// File: tb/tb_alu_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_unit
//  Description : Self-checking bench for alu_unit: directed cases plus
//                randomized operations checked against an arithmetic model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_unit;

    logic        CLK;
    logic        RST_X;
    logic [31:0] lhs;
    logic [31:0] rhs;
    logic [4:0]  op;
    logic [31:0] res;

    int n_checks = 0;
    int n_fail   = 0;

    alu_unit #(.WIDTH(32)) u_dut (
        .CLK   (CLK),
        .RST_X (RST_X),
        .lhs   (lhs),
        .rhs   (rhs),
        .op    (op),
        .res   (res)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: plain 64-bit integer arithmetic on the operand values.
    function automatic logic [31:0] ref_alu(input int unsigned o, input logic [31:0] a, input logic [31:0] b);
        longint ua, ub, sa, sb, p2, r;
        logic [63:0] rv;
        int unsigned sh;
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        sa = (a >= 32'h80000000) ? ua - 64'sd4294967296 : ua;
        sb = (b >= 32'h80000000) ? ub - 64'sd4294967296 : ub;
        sh = int'(ub % 32);
        p2 = 1;
        for (int i = 0; i < 32; i++) if (i < int'(sh)) p2 = p2 * 2;
        case (o)
            1:  r = ua + ub;
            2:  r = ua - ub;
            3:  r = ua * p2;
            4:  r = (sa < sb) ? 1 : 0;
            5:  r = (ua < ub) ? 1 : 0;
            6:  r = longint'({32'd0, a ^ b});
            7:  r = ua / p2;
            8:  r = (sa >= 0) ? sa / p2 : -((-sa + p2 - 1) / p2);
            9:  r = longint'({32'd0, a | b});
            10: r = longint'({32'd0, a & b});
            11: r = (ua == ub) ? 1 : 0;
            12: r = (ua != ub) ? 1 : 0;
            13: r = (sa < sb) ? 1 : 0;
            14: r = (sa >= sb) ? 1 : 0;
            15: r = (ua < ub) ? 1 : 0;
            16: r = (ua >= ub) ? 1 : 0;
            default: r = 0;
        endcase
        rv = r;
        return rv[31:0];
    endfunction

    // Present one operation at the falling edge and check it after the next rising edge.
    task automatic issue(input string tag, input int unsigned o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp);
        @(negedge CLK);
        op  = o[4:0];
        lhs = a;
        rhs = b;
        @(posedge CLK);
        #1;
        check(tag, res, exp);
    endtask

    typedef struct {
        string       tag;
        int unsigned o;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[$];
    logic [31:0] specials[8] = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000,
                                 32'h7FFFFFFF, 32'h1F, 32'h20, 32'h5};

    initial begin
        RST_X = 1'b0;
        op    = 5'd1;
        lhs   = 32'd5;
        rhs   = 32'd7;

        // Reset clears with no clock edge and holds across edges.
        #2;
        check("reset_no_edge", res, 32'h0);
        @(posedge CLK);
        #1;
        check("reset_hold", res, 32'h0);

        @(negedge CLK);
        RST_X = 1'b1;
        @(posedge CLK);
        #1;
        check("first_add", res, 32'd12);

        vecs = '{
            '{"sub_wrap",  2,  32'h0,        32'h1,        32'hFFFFFFFF},
            '{"add_wrap",  1,  32'hFFFFFFFF, 32'h2,        32'h1},
            '{"xor",       6,  32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0},
            '{"or",        9,  32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0},
            '{"and",       10, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000},
            '{"sll_mask",  3,  32'h1,        32'h23,       32'h8},
            '{"srl_31",    7,  32'h80000000, 32'd31,       32'h1},
            '{"sra_4",     8,  32'h80000000, 32'd4,        32'hF8000000},
            '{"sra_0",     8,  32'h80000000, 32'd0,        32'h80000000},
            '{"slt",       4,  32'hFFFFFFFF, 32'h1,        32'h1},
            '{"sltu",      5,  32'hFFFFFFFF, 32'h1,        32'h0},
            '{"lt",        13, 32'hFFFFFFFF, 32'h1,        32'h1},
            '{"ge",        14, 32'hFFFFFFFF, 32'h1,        32'h0},
            '{"ltu",       15, 32'hFFFFFFFF, 32'h1,        32'h0},
            '{"geu",       16, 32'hFFFFFFFF, 32'h1,        32'h1},
            '{"eq",        11, 32'd7,        32'd7,        32'h1},
            '{"neq",       12, 32'd7,        32'd7,        32'h0},
            '{"lt_min",    13, 32'h80000000, 32'h0,        32'h1},
            '{"ge_equal",  14, 32'd5,        32'd5,        32'h1},
            '{"geu_zero",  16, 32'd0,        32'd0,        32'h1},
            '{"b2b_add",   1,  32'd1,        32'd1,        32'd2},
            '{"b2b_sub",   2,  32'd9,        32'd4,        32'd5},
            '{"b2b_nop",   0,  32'd9,        32'd4,        32'd0},
            '{"b2b_rsvd",  20, 32'd9,        32'd4,        32'd0}
        };
        foreach (vecs[i]) issue(vecs[i].tag, vecs[i].o, vecs[i].a, vecs[i].b, vecs[i].exp);

        // Reset pulse between edges mid-stream.
        issue("pre_pulse", 1, 32'd100, 32'd23, 32'd123);
        @(negedge CLK);
        op  = 5'd2;
        lhs = 32'd9;
        rhs = 32'd4;
        #1;
        RST_X = 1'b0;
        #1;
        check("pulse_clear", res, 32'h0);
        #1;
        RST_X = 1'b1;
        #1;
        check("pulse_hold", res, 32'h0);
        @(posedge CLK);
        #1;
        check("pulse_resume", res, 32'd5);

        // Randomized operations against the model.
        for (int k = 0; k < 400; k++) begin
            int unsigned o;
            logic [31:0] a, b;
            o = $urandom_range(0, 31);
            a = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 7)] : $urandom;
            b = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 7)] : $urandom;
            issue($sformatf("rand_op%0d", o), o, a, b, ref_alu(o, a, b));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
